// File: rtl/debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_multi                                               |
// | Description : N independent switch debounce channels. Each channel has a   |
// |               2-flop synchroniser and a symmetric stability filter, so     |
// |               press and release are both filtered. Outputs per channel:    |
// |               registered clean level and 1-cycle rise/fall pulses.         |
// |               Optional auto-repeat for held buttons is compiled in by      |
// |               defining DEBOUNCE_REPEAT_EN; otherwise rpt is tied to 0.     |
// | Ports       : clk      - system clock                                      |
// |               reset_n  - asynchronous active-low reset                     |
// |               noisy    - raw asynchronous inputs, bit i = channel i        |
// |               clean    - debounced level per channel                       |
// |               rise     - 1-cycle pulse on clean 0->1                       |
// |               fall     - 1-cycle pulse on clean 1->0                       |
// |               rpt      - 1-cycle auto-repeat pulse while clean is held     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debounce_multi #(
    parameter int N           = 4,
    parameter int DELAY       = 1000000,
    parameter bit INIT        = 1'b0,
    parameter int REPEAT_HOLD = 50000000,
    parameter int REPEAT_RATE = 10000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] noisy,
    output logic [N-1:0] clean,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] rpt
);

    localparam int               CNT_W  = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DELAY - 1);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int               RPT_MAX   = (REPEAT_HOLD > REPEAT_RATE) ? REPEAT_HOLD : REPEAT_RATE;
    localparam int               RPT_W     = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] C_HOLD_M1 = RPT_W'(REPEAT_HOLD - 1);
    localparam logic [RPT_W-1:0] C_RATE_M1 = RPT_W'(REPEAT_RATE - 1);
`endif

    // Plain two-stage synchroniser; nothing sits between the stages so the
    // first flop has a full cycle to resolve metastability.
    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= {N{INIT}};
            r_s2 <= {N{INIT}};
        end else begin
            r_s1 <= noisy;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_clean;
            logic             r_rise;
            logic             r_fall;
            logic             w_mis;
            logic             w_flip;

            // The counter only runs while the synchronised input disagrees
            // with the clean level; any agreeing cycle restarts it, which is
            // what rejects glitches shorter than DELAY cycles.
            assign w_mis  = r_s2[gi] ^ r_clean;
            assign w_flip = w_mis && (r_cnt == C_LAST);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt   <= '0;
                    r_clean <= INIT;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_rise <= w_flip &  r_s2[gi];
                    r_fall <= w_flip & ~r_s2[gi];
                    if (!w_mis || w_flip) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_flip) begin
                        r_clean <= r_s2[gi];
                    end
                end
            end

            assign clean[gi] = r_clean;
            assign rise[gi]  = r_rise;
            assign fall[gi]  = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
            logic [RPT_W-1:0] r_rcnt;
            logic             r_armed;   // first pulse done, now pacing at REPEAT_RATE
            logic             r_rpt;
            logic             w_fire;

            // A flip while clean is high is a fall; suppressing the pulse on
            // that edge keeps rpt away from fall and cancels the pending repeat.
            assign w_fire = r_clean && !w_flip &&
                            (r_rcnt == (r_armed ? C_RATE_M1 : C_HOLD_M1));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rcnt  <= '0;
                    r_armed <= 1'b0;
                    r_rpt   <= 1'b0;
                end else begin
                    r_rpt <= w_fire;
                    // Clean low (including the edge that raises it) holds the
                    // counter at zero, so it reads 0 during the rise cycle.
                    if (!r_clean || w_flip) begin
                        r_rcnt  <= '0;
                        r_armed <= 1'b0;
                    end else if (w_fire) begin
                        r_rcnt  <= '0;
                        r_armed <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
            end

            assign rpt[gi] = r_rpt;
`else
            assign rpt[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire
